// File: rtl/crypto_arbiter.sv
// Round-robin arbiter sharing one encrypt/decrypt core between two requesters.
// Issues a one-cycle start, waits for the matching done or a timeout, then acks.
module crypto_arbiter #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        req_dec,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              start_enc,
    output logic              start_dec,
    output logic [DATA_W-1:0] core_din,
    input  logic              enc_done,
    input  logic              dec_done,
    input  logic [DATA_W-1:0] core_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic            sel;
    logic            sel_dec;
    logic            prio;
    logic [TO_W-1:0] cnt;

    logic            pick;
    logic            pick_dec;
    logic            done_hit;

    // With both requesting, prio names the requester that was not served last.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = prio;
            default: pick = 1'b0;
        endcase
        pick_dec = req_dec[pick];
        done_hit = sel_dec ? dec_done : enc_done;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            sel_dec   <= 1'b0;
            prio      <= 1'b0;
            cnt       <= '0;
            gnt       <= '0;
            ack       <= '0;
            err       <= '0;
            start_enc <= 1'b0;
            start_dec <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= '0;
            core_din  <= '0;
        end else begin
            start_enc <= 1'b0;
            start_dec <= 1'b0;
            ack       <= '0;
            err       <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        sel       <= pick;
                        sel_dec   <= pick_dec;
                        core_din  <= pick ? req_data1 : req_data0;
                        gnt       <= pick ? 2'b10 : 2'b01;
                        start_dec <= pick_dec;
                        start_enc <= ~pick_dec;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A matching done on the final counted cycle still wins over timeout.
                    if (done_hit) begin
                        rsp_data <= core_dout;
                        ack      <= gnt;
                        state    <= S_RESP;
                    end else if (cnt == TO_LAST) begin
                        ack   <= gnt;
                        err   <= gnt;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    prio  <= ~sel;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_arbiter.sv
// Table-driven bench for crypto_arbiter with a scoreboard queue of expected acks.
// The bench plays both requesters and the core; TIMEOUT is shortened to 8.
module tb_crypto_arbiter;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        req_dec;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        gnt;
    logic [1:0]        ack;
    logic [1:0]        err;
    logic [DATA_W-1:0] rsp_data;
    logic              start_enc;
    logic              start_dec;
    logic [DATA_W-1:0] core_din;
    logic              enc_done;
    logic              dec_done;
    logic [DATA_W-1:0] core_dout;
    logic              busy;

    crypto_arbiter #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_dec  (req_dec),
        .req_data0(req_data0),
        .req_data1(req_data1),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .rsp_data (rsp_data),
        .start_enc(start_enc),
        .start_dec(start_dec),
        .core_din (core_din),
        .enc_done (enc_done),
        .dec_done (dec_done),
        .core_dout(core_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        ack;
        logic [1:0]        err;
        logic [DATA_W-1:0] data;
    } sb_t;

    // done_k / wrong_k: WAIT cycle (1-based) carrying the matching / other done; 0 = never.
    typedef struct {
        logic [1:0] r;
        logic [1:0] dec;
        int         done_k;
        int         wrong_k;
        bit         issue_done;
        logic [1:0] exp_gnt;
        int         exp_m;
        bit         exp_err;
    } vec_t;

    sb_t               sb[$];
    sb_t               mon_e;
    vec_t              vecs[12];
    logic [DATA_W-1:0] last_rsp;
    int                n_total = 0;
    int                n_pass  = 0;
    int                start_count = 0;
    bit                both_gnt_seen = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (gnt == 2'b11) both_gnt_seen = 1'b1;
        if (start_enc) start_count++;
        if (start_dec) start_count++;
        if (rst && ack != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {126'd0, ack}, '0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack", {126'd0, ack}, {126'd0, mon_e.ack});
                chk("err", {126'd0, err}, {126'd0, mon_e.err});
                chk("rsp_data", rsp_data, mon_e.data);
            end
        end
    end

    task automatic do_txn(input int idx, input vec_t v);
        logic [DATA_W-1:0] d0, d1, dout, opnd;
        sb_t e;
        bit  op, got, match, wrong, din_bad;
        int  m, s0;
        d0   = (idx == 4) ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
        d1   = {$urandom, $urandom, $urandom, $urandom};
        dout = {$urandom, $urandom, $urandom, $urandom};
        op   = v.exp_gnt[1] ? v.dec[1] : v.dec[0];
        opnd = v.exp_gnt[1] ? d1 : d0;
        req_data0 = d0;
        req_data1 = d1;
        req_dec   = v.dec;
        req       = v.r;
        e.ack  = v.exp_gnt;
        e.err  = v.exp_err ? v.exp_gnt : 2'b00;
        e.data = v.exp_err ? last_rsp : dout;
        sb.push_back(e);
        if (!v.exp_err) last_rsp = dout;

        tick();
        m  = 1;
        s0 = start_count;
        chk($sformatf("gnt[%0d]", idx), {126'd0, gnt}, {126'd0, v.exp_gnt});
        chk($sformatf("start_enc[%0d]", idx), {127'd0, start_enc}, {127'd0, ~op});
        chk($sformatf("start_dec[%0d]", idx), {127'd0, start_dec}, {127'd0, op});
        chk($sformatf("core_din[%0d]", idx), core_din, opnd);
        chk($sformatf("busy[%0d]", idx), {127'd0, busy}, 128'd1);

        got = 1'b0;
        din_bad = 1'b0;
        while (!got && m < 40) begin
            if (m >= 2 && core_din !== opnd) din_bad = 1'b1;
            match = (v.done_k > 0 && m == v.done_k + 1) || (v.issue_done && m == 1);
            wrong = (v.wrong_k > 0 && m == v.wrong_k + 1);
            enc_done  = op ? wrong : match;
            dec_done  = op ? match : wrong;
            core_dout = match ? dout : ~dout;
            tick();
            m++;
            if (ack != 2'b00) got = 1'b1;
        end
        enc_done = 1'b0;
        dec_done = 1'b0;
        chk($sformatf("ack_latency[%0d]", idx), 128'(m), 128'(v.exp_m));
        chk($sformatf("core_din_held[%0d]", idx), {127'd0, din_bad}, '0);

        tick();
        req = req & ~v.exp_gnt;
        chk($sformatf("idle_gnt[%0d]", idx), {126'd0, gnt}, '0);
        chk($sformatf("idle_busy[%0d]", idx), {127'd0, busy}, '0);
        chk($sformatf("start_once[%0d]", idx), 128'(start_count - s0), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b11, 2'b00, 2, 0, 1'b0, 2'b01, 4,  1'b0};
        vecs[1]  = '{2'b11, 2'b00, 3, 0, 1'b0, 2'b10, 5,  1'b0};
        vecs[2]  = '{2'b11, 2'b00, 1, 0, 1'b0, 2'b01, 3,  1'b0};
        vecs[3]  = '{2'b11, 2'b00, 2, 0, 1'b0, 2'b10, 4,  1'b0};
        vecs[4]  = '{2'b01, 2'b00, 4, 0, 1'b0, 2'b01, 6,  1'b0};
        vecs[5]  = '{2'b10, 2'b10, 3, 1, 1'b0, 2'b10, 5,  1'b0};
        vecs[6]  = '{2'b01, 2'b00, 0, 0, 1'b0, 2'b01, 10, 1'b1};
        vecs[7]  = '{2'b10, 2'b10, 1, 0, 1'b0, 2'b10, 3,  1'b0};
        vecs[8]  = '{2'b01, 2'b01, 8, 0, 1'b0, 2'b01, 10, 1'b0};
        vecs[9]  = '{2'b10, 2'b00, 2, 0, 1'b1, 2'b10, 4,  1'b0};
        vecs[10] = '{2'b10, 2'b10, 0, 5, 1'b0, 2'b10, 10, 1'b1};
        vecs[11] = '{2'b11, 2'b11, 2, 0, 1'b0, 2'b01, 4,  1'b0};

        rst = 1'b0;
        req = '0;
        req_dec = '0;
        req_data0 = '0;
        req_data1 = '0;
        enc_done = 1'b0;
        dec_done = 1'b0;
        core_dout = '0;
        last_rsp = '0;
        #12;
        chk("rst_gnt", {126'd0, gnt}, '0);
        chk("rst_ack_err", {124'd0, ack, err}, '0);
        chk("rst_start", {126'd0, start_enc, start_dec}, '0);
        chk("rst_busy", {127'd0, busy}, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_core_din", core_din, '0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 12; i++) do_txn(i, vecs[i]);
        req = '0;

        // Abandon a transaction mid-WAIT; requester 1 is pending when reset releases.
        req = 2'b01;
        req_dec = 2'b00;
        req_data0 = {4{32'hDEADBEEF}};
        tick();
        tick();
        tick();
        chk("busy_before_reset", {127'd0, busy}, 128'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", {126'd0, gnt}, '0);
        chk("mid_rst_ack_err", {124'd0, ack, err}, '0);
        chk("mid_rst_start", {126'd0, start_enc, start_dec}, '0);
        chk("mid_rst_busy", {127'd0, busy}, '0);
        chk("mid_rst_rsp_data", rsp_data, '0);
        chk("mid_rst_core_din", core_din, '0);
        req = 2'b10;
        last_rsp = '0;
        #2;
        rst = 1'b1;
        do_txn(12, '{2'b10, 2'b00, 2, 0, 1'b0, 2'b10, 4, 1'b0});
        do_txn(13, '{2'b11, 2'b00, 0, 0, 1'b0, 2'b01, 10, 1'b1});
        req = '0;
        tick();
        tick();

        chk("gnt_never_both", {127'd0, both_gnt_seen}, '0);
        chk("sb_drained", 128'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
